// File: rtl/spn_round_cipher.sv
// Iterative substitution-permutation block cipher, one round per clock.
// Round key evolves by a 13-bit rotate plus round counter injection.
module spn_round_cipher #(
  parameter int BLOCK_W = 128,
  parameter int ROUNDS  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [BLOCK_W-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               busy
);

  localparam int NIB = BLOCK_W / 4;
  localparam logic [7:0] LAST = 8'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] s_q, s_d;
  logic [BLOCK_W-1:0] k_q, k_d;
  logic [7:0]         rcnt_q, rcnt_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;

  logic [BLOCK_W-1:0] mix;
  logic [BLOCK_W-1:0] sub;
  logic [BLOCK_W-1:0] s_nxt;
  logic [BLOCK_W-1:0] k_nxt;
  logic [BLOCK_W-1:0] rc_ext;
  logic               last_rnd;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      4'hF: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] sub_layer(
    input logic [BLOCK_W-1:0] x
  );
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < NIB; i++) begin
      y[i*4 +: 4] = sbox(x[i*4 +: 4]);
    end
    return y;
  endfunction

  assign mix      = s_q ^ k_q;
  assign sub      = sub_layer(mix);
  assign s_nxt    = {sub[BLOCK_W-9:0], sub[BLOCK_W-1:BLOCK_W-8]};
  assign rc_ext   = {{(BLOCK_W-8){1'b0}}, rcnt_q};
  assign k_nxt    = {k_q[BLOCK_W-14:0], k_q[BLOCK_W-1:BLOCK_W-13]}
                    ^ rc_ext;
  assign last_rnd = (rcnt_q == LAST);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    rcnt_d  = rcnt_q;
    ct_d    = ct_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = plaintext;
          k_d     = key;
          rcnt_d  = 8'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        // Last round folds in whitening with the next round key;
        // s, k, rcnt hold so rcnt never wraps at ROUNDS=255.
        if (last_rnd) begin
          ct_d    = s_nxt ^ k_nxt;
          state_d = DONE;
        end else begin
          s_d    = s_nxt;
          k_d    = k_nxt;
          rcnt_d = rcnt_q + 8'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          s_d     = '0;
          k_d     = '0;
          rcnt_d  = '0;
          ct_d    = '0;
          state_d = IDLE;
        end
      end
      default: begin
        s_d     = '0;
        k_d     = '0;
        rcnt_d  = '0;
        ct_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      rcnt_q  <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      rcnt_q  <= rcnt_d;
      ct_q    <= ct_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q == RUN);
  assign out_valid  = (state_q == DONE);
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_spn_round_cipher.sv
// Scoreboard bench: default, ROUNDS=1 and 16-bit/255-round instances.
// Expected ciphertexts come from an independent reference model.
module tb_spn_round_cipher;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         iv = 0, ir, ov, ordy = 1, bz;
  logic [127:0] pt = 0, ky = 0, ct;

  logic         iv1 = 0, ir1, ov1, ordy1 = 1, bz1;
  logic [127:0] pt1 = 0, ky1 = 0, ct1;

  logic         iv2 = 0, ir2, ov2, ordy2 = 1, bz2;
  logic [15:0]  pt2 = 0, ky2 = 0, ct2;

  spn_round_cipher u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv), .in_ready(ir),
    .plaintext(pt), .key(ky),
    .out_valid(ov), .out_ready(ordy),
    .ciphertext(ct), .busy(bz)
  );

  spn_round_cipher #(.BLOCK_W(128), .ROUNDS(1)) u_r1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(ir1),
    .plaintext(pt1), .key(ky1),
    .out_valid(ov1), .out_ready(ordy1),
    .ciphertext(ct1), .busy(bz1)
  );

  spn_round_cipher #(.BLOCK_W(16), .ROUNDS(255)) u_w16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(ir2),
    .plaintext(pt2), .key(ky2),
    .out_valid(ov2), .out_ready(ordy2),
    .ciphertext(ct2), .busy(bz2)
  );

  typedef struct {
    logic [127:0] ct;
    int           acc;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ref_sb(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'hC56B90AD3EF84712;
    return tbl[(15 - x) * 4 +: 4];
  endfunction

  function automatic logic [127:0] ref_ct(input logic [127:0] p,
                                          input logic [127:0] k0,
                                          input int w,
                                          input int r);
    logic [127:0] m, s, k, t, u, kn;
    m = (w == 128) ? '1 : ((128'd1 << w) - 1);
    s = p & m;
    k = k0 & m;
    for (int i = 1; i <= r; i++) begin
      t = s ^ k;
      u = '0;
      for (int j = 0; j < w / 4; j++) u[j*4 +: 4] = ref_sb(t[j*4 +: 4]);
      u  = ((u << 8) | (u >> (w - 8))) & m;
      kn = (((k << 13) | (k >> (w - 13))) & m) ^ 128'(i);
      if (i == r) return u ^ kn;
      s = u;
      k = kn;
    end
    return '0;
  endfunction

  logic ov_prev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (ov && !ov_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected none", ct);
      end else begin
        e = exp_q.pop_front();
        check("ct", ct, e.ct);
        check("latency", 128'(cyc - e.acc), 128'd8);
      end
    end
    ov_prev = ov;
  end

  task automatic send(input logic [127:0] p, input logic [127:0] k);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ir && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 128'(ir), 128'd1);
    pt = p;
    ky = k;
    iv = 1;
    @(posedge clk);
    #1;
    iv = 0;
    e.ct = ref_ct(p, k, 128, 8);
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || !ir) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] held, a, b;
    int st, n;

    #12;
    check("rst_in_ready", 128'(ir), 128'd1);
    check("rst_out_valid", 128'(ov), 128'd0);
    check("rst_busy", 128'(bz), 128'd0);
    check("rst_ct", ct, 128'd0);
    #10 rst_n = 1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 128'(ir), 128'd1);

    for (int i = 0; i < 20; i++) begin
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      send(a, b);
    end
    wait_drain();

    ordy = 0;
    send(128'h0123456789ABCDEF_FEDCBA9876543210,
         128'h0F1E2D3C4B5A6978_8796A5B4C3D2E1F0);
    n = 0;
    @(negedge clk);
    while (!ov && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid", 128'(ov), 128'd1);
    held = ct;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_ct", ct, held);
      check("bp_hold_valid", 128'(ov), 128'd1);
    end
    check("bp_no_ready", 128'(ir), 128'd0);
    ordy = 1;
    @(posedge clk);
    #1;
    check("hs_valid_low", 128'(ov), 128'd0);
    check("hs_ct_zero", ct, 128'd0);
    check("hs_ready", 128'(ir), 128'd1);

    send(128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0,
         128'h00112233_44556677_8899AABB_CCDDEEFF);
    iv = 1;
    for (int i = 0; i < 6; i++) begin
      pt = ~pt;
      ky = {ky[126:0], ky[127]};
      @(negedge clk);
      check("run_busy", 128'(bz), 128'd1);
      check("run_no_ready", 128'(ir), 128'd0);
      check("run_ct_zero", ct, 128'd0);
    end
    iv = 0;
    wait_drain();

    send(128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A,
         128'h13579BDF_2468ACE0_13579BDF_2468ACE0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("abort_valid", 128'(ov), 128'd0);
    check("abort_busy", 128'(bz), 128'd0);
    check("abort_ct", ct, 128'd0);
    check("abort_ready", 128'(ir), 128'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check("abort_rel_ready", 128'(ir), 128'd1);
    send(128'h00000000_00000001_00000000_00000002,
         128'hFFFFFFFF_FFFFFFFF_00000000_00000000);
    wait_drain();

    @(negedge clk);
    iv1 = 1;
    @(posedge clk);
    #1;
    iv1 = 0;
    check("r1_busy", 128'(bz1), 128'd1);
    check("r1_not_valid", 128'(ov1), 128'd0);
    @(posedge clk);
    #1;
    check("r1_valid", 128'(ov1), 128'd1);
    check("r1_ct_zero_vec", ct1,
          128'hCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCD);
    @(posedge clk);
    #1;
    check("r1_hs_valid", 128'(ov1), 128'd0);
    check("r1_hs_ct", ct1, 128'd0);
    check("r1_hs_ready", 128'(ir1), 128'd1);
    a = 128'hFEDCBA98_76543210_01234567_89ABCDEF;
    b = 128'h11111111_22222222_33333333_44444444;
    @(negedge clk);
    pt1 = a;
    ky1 = b;
    iv1 = 1;
    @(posedge clk);
    #1;
    iv1 = 0;
    @(posedge clk);
    #1;
    check("r1_model", ct1, ref_ct(a, b, 128, 1));

    a = 128'(16'hBEEF);
    b = 128'(16'h1234);
    @(negedge clk);
    pt2 = a[15:0];
    ky2 = b[15:0];
    iv2 = 1;
    @(posedge clk);
    #1;
    iv2 = 0;
    st = cyc;
    n = 0;
    while (!ov2 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w16_latency", 128'(cyc - st), 128'd255);
    check("w16_ct", 128'(ct2), ref_ct(a, b, 16, 255));

    repeat (3) @(negedge clk);
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spn_round_cipher.md
SPN_ROUND_CIPHER -- requirements
Module: spn_round_cipher

Interface
REQ-001 SHALL have parameter BLOCK_W, default 128: block and key width in bits; must be a multiple of 16 and at least 16.
REQ-002 SHALL have parameter ROUNDS, default 8: number of substitution-permutation rounds; legal range is 1 to 255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: plaintext and key are presented.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a new request.
REQ-007 SHALL have port plaintext, input, BLOCK_W bits.
REQ-008 SHALL have port key, input, BLOCK_W bits.
REQ-009 SHALL have port out_valid, output, 1 bit: ciphertext is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts ciphertext.
REQ-011 SHALL have port ciphertext, output, BLOCK_W bits.
REQ-012 SHALL have port busy, output, 1 bit: high while rounds are executing.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE; encoding is free.
REQ-014 SHALL drive in_ready=1 only in IDLE, busy=1 only in RUN, and out_valid=1 only in DONE; all three are registered or decoded from state only.
REQ-015 SHALL accept a request on an edge where in_valid and in_ready are both 1, latching s<=plaintext, k<=key and rcnt<=1, and moving to RUN.
REQ-016 SHALL ignore plaintext, key and in_valid outside IDLE.
REQ-017 SHALL, in RUN, execute one round per cycle: t=s^k; u=S(t); s<=rotl(u,8); k<=rotl(k,13)^{zero-extend rcnt to BLOCK_W}; rcnt<=rcnt+1.
REQ-018 SHALL define S as the 4-bit S-box applied to every nibble in parallel, mapping 0..F to C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
REQ-019 SHALL, on the RUN edge where rcnt==ROUNDS, register ciphertext<=rotl(S(s^k),8)^(rotl(k,13)^rcnt) as final key whitening with the next round key, and move to DONE.
REQ-020 SHALL give a latency of exactly ROUNDS clock edges from the accept edge to out_valid=1.
REQ-021 SHALL hold ciphertext and out_valid stable in DONE while out_ready=0, for unbounded back-pressure.
REQ-022 SHALL, on a DONE edge with out_ready=1, return to IDLE, clear out_valid and zeroize ciphertext, s, k and rcnt to 0.
REQ-023 SHALL NOT permit same-cycle re-accept: in_ready rises the cycle after the output handshake.
REQ-024 SHALL ignore an out_ready that is high in IDLE or RUN.
REQ-025 SHALL keep ciphertext at 0 whenever out_valid=0, so no partial state is exposed.
REQ-026 SHALL size rcnt as 8 bits; no wrap occurs because ROUNDS<=255.

Reset
REQ-027 SHALL, on rst_n=0 and regardless of clk, enter IDLE and set s, k, rcnt and ciphertext to 0, out_valid=0, busy=0 and in_ready=1.
REQ-028 SHALL, if reset occurs mid-RUN or in DONE, abort the operation with no output produced; after release the block is ready for a new request.
REQ-029 SHALL make in_ready=1 observable in the first cycle after rst_n deasserts.

Verification
REQ-030 SHALL cover: ROUNDS=1, BLOCK_W=128, plaintext=0, key=0 -> one edge after accept, out_valid=1 and ciphertext=0xCCCCCCCC_CCCCCCCC_CCCCCCCC_CCCCCCCD.
REQ-031 SHALL cover: default parameters with 20 random vectors -> each matches the bit-accurate reference model, and out_valid rises exactly 8 edges after the accept edge.
REQ-032 SHALL cover: out_ready held at 0 for 10 cycles in DONE -> ciphertext is unchanged; after the handshake, ciphertext=0 and in_ready=1 in the next cycle.
REQ-033 SHALL cover: plaintext and key toggled and in_valid held high during RUN -> result is unchanged and no second accept occurs until IDLE.
REQ-034 SHALL cover: rst_n pulsed low at round 4 of 8 -> out_valid, busy and ciphertext are 0 immediately; a fresh request afterwards completes correctly.
REQ-035 SHALL cover: BLOCK_W=16, ROUNDS=255 -> latency is 255 edges and the result matches the reference model.
